pixel_shifter_mc: RTL and testbench

PIXEL_SHIFTER_MC -- requirements
Module: pixel_shifter_mc

---
 rtl/pixel_shifter_mc.sv | 163 ++++++++++++++++
 tb/tb_pixel_shifter_mc.sv | 382 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pixel_shifter_mc.sv
// Pixel shifter with multicolour support.
//
// Captured pixel/attribute data passes through DELAY dot-rate stages. When the
// dot position matches the captured fine scroll, the oldest stage is loaded into
// a shift register. Pixels are emitted MSB first, eff_bpp bits at a time, and
// each code is held for eff_bpp dots so a cell always spans DATA_WIDTH dots.
//
// Ports:
//   clk_dot4x      sole clock, rising edge
//   rst            synchronous active-high reset
//   dot_rising_0   dot-rate enable (one clk_dot4x cycle per dot)
//   capture        strobe for pixels_read / char_read / xscroll
//   pixels_read    fetched pixel byte
//   char_read      fetched attribute word (colour nibble in MSBs)
//   xscroll        fine scroll, used after the next capture
//   xpos_mod       dot position within the cell
//   bpp_mode       00=1bpp, 01=2bpp (see mc_gate), 10=4bpp, 11=1bpp
//   mc_gate        in mode 01, 2bpp only when the attribute MSB is set
//   pix_code       current pixel code, zero-extended to 4 bits
//   pix_attr       attribute word of the current pixel
//   is_background  1 when the MSB of the current pixel code is 0
//
// Build option: define PIXEL_SHIFTER_4BPP_EN to make bpp_mode=10 select 4bpp;
// otherwise it behaves as 1bpp and no 4bpp logic is built.

module pixel_shifter_mc #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned CHAR_WIDTH = 12,
  parameter int unsigned DELAY      = 2
) (
  input  logic                          clk_dot4x,
  input  logic                          rst,
  input  logic                          dot_rising_0,
  input  logic                          capture,
  input  logic [DATA_WIDTH-1:0]         pixels_read,
  input  logic [CHAR_WIDTH-1:0]         char_read,
  input  logic [$clog2(DATA_WIDTH)-1:0] xscroll,
  input  logic [$clog2(DATA_WIDTH)-1:0] xpos_mod,
  input  logic [1:0]                    bpp_mode,
  input  logic                          mc_gate,
  output logic [3:0]                    pix_code,
  output logic [CHAR_WIDTH-1:0]         pix_attr,
  output logic                          is_background
);

  localparam int unsigned XW = $clog2(DATA_WIDTH);

`ifdef PIXEL_SHIFTER_4BPP_EN
  localparam int unsigned HoldW = 2;
  localparam int unsigned BppW  = 3;
`else
  localparam int unsigned HoldW = 1;
  localparam int unsigned BppW  = 2;
`endif

  // Stage 0 is the capture register; stages 1..DELAY advance on each dot.
  logic [DATA_WIDTH-1:0] pix_stage_q  [DELAY+1];
  logic [CHAR_WIDTH-1:0] char_stage_q [DELAY+1];
  logic [XW-1:0]         xscroll_q;

  logic [DATA_WIDTH-1:0] shreg_q, shreg_d;
  logic [CHAR_WIDTH-1:0] pix_attr_q, pix_attr_d;
  logic [BppW-1:0]       eff_bpp_q, eff_bpp_d;  // bits per pixel: 1, 2 or 4
  logic [HoldW-1:0]      hold_q, hold_d;
  logic [3:0]            pix_code_q, pix_code_d;
  logic                  is_bg_q, is_bg_d;

  logic                  load;
  logic [BppW-1:0]       load_bpp;

  assign load = dot_rising_0 && (xpos_mod == xscroll_q);

  // Effective bpp for the cell about to be loaded, from the oldest stage's attribute.
  always_comb begin
    load_bpp = BppW'(1);
    case (bpp_mode)
      2'b01: begin
        if (!mc_gate || char_stage_q[DELAY][CHAR_WIDTH-1]) begin
          load_bpp = BppW'(2);
        end
      end
`ifdef PIXEL_SHIFTER_4BPP_EN
      2'b10: load_bpp = BppW'(4);
`endif
      default: load_bpp = BppW'(1);
    endcase
  end

  always_comb begin
    shreg_d    = shreg_q;
    pix_attr_d = pix_attr_q;
    eff_bpp_d  = eff_bpp_q;
    hold_d     = hold_q;
    pix_code_d = pix_code_q;
    is_bg_d    = is_bg_q;

    if (load) begin
      shreg_d    = pix_stage_q[DELAY];
      pix_attr_d = char_stage_q[DELAY];
      eff_bpp_d  = load_bpp;
      hold_d     = HoldW'(load_bpp - BppW'(1));
    end else if (dot_rising_0) begin
      if (hold_q == '0) begin
        shreg_d = shreg_q << eff_bpp_q;
        hold_d  = HoldW'(eff_bpp_q - BppW'(1));
      end else begin
        hold_d = hold_q - HoldW'(1);
      end
    end

    // Output tracks the post-edge shift register, so it lags load by one clock.
    if (dot_rising_0) begin
      case (eff_bpp_d)
        BppW'(2): pix_code_d = {2'b00, shreg_d[DATA_WIDTH-1 -: 2]};
`ifdef PIXEL_SHIFTER_4BPP_EN
        BppW'(4): pix_code_d = shreg_d[DATA_WIDTH-1 -: 4];
`endif
        default:  pix_code_d = {3'b000, shreg_d[DATA_WIDTH-1]};
      endcase
      // Code MSB always sits at the top of the shift register.
      is_bg_d = ~shreg_d[DATA_WIDTH-1];
    end
  end

  always_ff @(posedge clk_dot4x) begin
    if (rst) begin
      for (int unsigned i = 0; i <= DELAY; i++) begin
        pix_stage_q[i]  <= '0;
        char_stage_q[i] <= '0;
      end
      xscroll_q  <= '0;
      shreg_q    <= '0;
      pix_attr_q <= '0;
      eff_bpp_q  <= BppW'(1);
      hold_q     <= '0;
      pix_code_q <= '0;
      is_bg_q    <= 1'b1;
    end else begin
      if (capture) begin
        pix_stage_q[0]  <= pixels_read;
        char_stage_q[0] <= char_read;
        xscroll_q       <= xscroll;
      end
      if (dot_rising_0) begin
        for (int unsigned i = 1; i <= DELAY; i++) begin
          pix_stage_q[i]  <= pix_stage_q[i-1];
          char_stage_q[i] <= char_stage_q[i-1];
        end
      end
      shreg_q    <= shreg_d;
      pix_attr_q <= pix_attr_d;
      eff_bpp_q  <= eff_bpp_d;
      hold_q     <= hold_d;
      pix_code_q <= pix_code_d;
      is_bg_q    <= is_bg_d;
    end
  end

  assign pix_code      = pix_code_q;
  assign pix_attr      = pix_attr_q;
  assign is_background = is_bg_q;

endmodule

// File: tb/tb_pixel_shifter_mc.sv
module tb_pixel_shifter_mc;

  localparam int unsigned DW = 8;
  localparam int unsigned CW = 12;
  localparam int unsigned DL = 2;

  logic          clk_dot4x = 1'b0;
  logic          rst;
  logic          dot_rising_0;
  logic          capture;
  logic [DW-1:0] pixels_read;
  logic [CW-1:0] char_read;
  logic [2:0]    xscroll;
  logic [2:0]    xpos_mod;
  logic [1:0]    bpp_mode;
  logic          mc_gate;
  logic [3:0]    pix_code;
  logic [CW-1:0] pix_attr;
  logic          is_background;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk_dot4x = ~clk_dot4x;

  pixel_shifter_mc #(
    .DATA_WIDTH(DW),
    .CHAR_WIDTH(CW),
    .DELAY     (DL)
  ) dut (
    .clk_dot4x    (clk_dot4x),
    .rst          (rst),
    .dot_rising_0 (dot_rising_0),
    .capture      (capture),
    .pixels_read  (pixels_read),
    .char_read    (char_read),
    .xscroll      (xscroll),
    .xpos_mod     (xpos_mod),
    .bpp_mode     (bpp_mode),
    .mc_gate      (mc_gate),
    .pix_code     (pix_code),
    .pix_attr     (pix_attr),
    .is_background(is_background)
  );

  // Reference model: the loaded word is whatever stage 0 held DL dots earlier;
  // a load expands the cell into a list of DW per-dot codes that is consumed one per dot.
  typedef struct {
    logic [3:0]  code;
    int unsigned bpp;
  } dot_t;

  dot_t             cell_q[$];
  logic [CW+DW-1:0] hist_q[$];
  logic [DW-1:0]    m_pix;
  logic [CW-1:0]    m_chr;
  logic [2:0]       m_xs;
  logic [CW+DW-1:0] m_old;
  int unsigned      m_b;
  int unsigned      m_pv;
  dot_t             m_d;
  logic [3:0]       exp_code;
  logic             exp_bg;
  logic [CW-1:0]    exp_attr;

  function automatic int unsigned model_bpp(input logic [1:0] mode, input logic mc,
                                            input logic msb);
    case (mode)
      2'b01:   return (mc && !msb) ? 1 : 2;
`ifdef PIXEL_SHIFTER_4BPP_EN
      2'b10:   return 4;
`endif
      default: return 1;
    endcase
  endfunction

  always @(posedge clk_dot4x) begin
    if (rst) begin
      hist_q.delete();
      for (int i = 0; i < DL; i++) hist_q.push_back('0);
      cell_q.delete();
      m_pix    = '0;
      m_chr    = '0;
      m_xs     = '0;
      exp_code = '0;
      exp_bg   = 1'b1;
      exp_attr = '0;
    end else begin
      if (dot_rising_0) begin
        m_old = hist_q.pop_front();
        hist_q.push_back({m_chr, m_pix});
        if (xpos_mod == m_xs) begin
          m_b      = model_bpp(bpp_mode, mc_gate, m_old[CW+DW-1]);
          exp_attr = m_old[CW+DW-1:DW];
          m_pv     = int'(m_old[DW-1:0]);
          cell_q.delete();
          for (int i = 0; i < DW; i++) begin
            m_d.code = 4'((m_pv >> (DW - m_b * (i / m_b + 1))) & ((1 << m_b) - 1));
            m_d.bpp  = m_b;
            cell_q.push_back(m_d);
          end
        end
        if (cell_q.size() > 0) begin
          m_d      = cell_q.pop_front();
          exp_code = m_d.code;
          exp_bg   = ~m_d.code[m_d.bpp-1];
        end else begin
          exp_code = '0;
          exp_bg   = 1'b1;
        end
      end
      if (capture) begin
        m_pix = pixels_read;
        m_chr = char_read;
        m_xs  = xscroll;
      end
    end
  end

  task automatic cyc();
    @(posedge clk_dot4x);
    #1;
  endtask

  // Three idle clocks then one dot clock; outputs are sampled just after the dot edge.
  task automatic dot_step(input logic [2:0] xp);
    repeat (3) cyc();
    dot_rising_0 = 1'b1;
    xpos_mod     = xp;
    cyc();
    dot_rising_0 = 1'b0;
  endtask

  // Reset, capture one cell, and advance DL+1 dots without hitting the load position.
  task automatic prep_cell(input logic [7:0] pix, input logic [11:0] chr, input logic [2:0] xs,
                           input logic [1:0] mode, input logic mc);
    rst = 1'b1;
    cyc();
    rst          = 1'b0;
    pixels_read  = pix;
    char_read    = chr;
    xscroll      = xs;
    bpp_mode     = mode;
    mc_gate      = mc;
    capture      = 1'b1;
    cyc();
    capture = 1'b0;
    for (int k = 1; k <= 3; k++) dot_step(3'(int'(xs) + k));
  endtask

  task automatic test_reset();
    rst          = 1'b1;
    capture      = 1'b1;
    dot_rising_0 = 1'b1;
    pixels_read  = 8'hFF;
    char_read    = 12'hFFF;
    cyc();
    cyc();
    n_checks++;
    if (pix_code !== 4'h0) begin
      n_fail++;
      $display("FAIL reset_code: got %0h want 0", pix_code);
    end
    n_checks++;
    if (is_background !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_bg: got %0b want 1", is_background);
    end
    n_checks++;
    if (pix_attr !== 12'h000) begin
      n_fail++;
      $display("FAIL reset_attr: got %0h want 0", pix_attr);
    end
    capture      = 1'b0;
    dot_rising_0 = 1'b0;
    rst          = 1'b0;
  endtask

  task automatic test_1bpp();
    int ec[10] = '{1, 0, 1, 0, 0, 1, 0, 1, 0, 0};
    int eb[10] = '{0, 1, 0, 1, 1, 0, 1, 0, 1, 1};
    prep_cell(8'hA5, 12'h123, 3'd0, 2'b00, 1'b0);
    for (int i = 0; i < 10; i++) begin
      dot_step((i < 8) ? 3'(i) : 3'd1);
      n_checks++;
      if (pix_code !== 4'(ec[i]) || is_background !== 1'(eb[i])) begin
        n_fail++;
        $display("FAIL 1bpp dot %0d: got code %0h bg %0b want code %0h bg %0d",
                 i, pix_code, is_background, ec[i], eb[i]);
      end
    end
    n_checks++;
    if (pix_attr !== 12'h123) begin
      n_fail++;
      $display("FAIL 1bpp_attr: got %0h want 123", pix_attr);
    end
  endtask

  task automatic test_2bpp();
    int ec[10] = '{0, 0, 1, 1, 2, 2, 3, 3, 0, 0};
    int eb[10] = '{1, 1, 1, 1, 0, 0, 0, 0, 1, 1};
    prep_cell(8'h1B, 12'h000, 3'd2, 2'b01, 1'b0);
    for (int i = 0; i < 10; i++) begin
      dot_step((i < 8) ? 3'(2 + i) : 3'd3);
      n_checks++;
      if (pix_code !== 4'(ec[i]) || is_background !== 1'(eb[i])) begin
        n_fail++;
        $display("FAIL 2bpp dot %0d: got code %0h bg %0b want code %0h bg %0d",
                 i, pix_code, is_background, ec[i], eb[i]);
      end
    end
  endtask

  task automatic test_mc_gate();
    int ec1[10] = '{1, 0, 0, 0, 0, 0, 0, 0, 0, 0};
    int ec2[10] = '{2, 2, 0, 0, 0, 0, 0, 0, 0, 0};
    // Attribute MSB clear: gated down to 1bpp.
    prep_cell(8'h80, 12'h7AB, 3'd0, 2'b01, 1'b1);
    for (int i = 0; i < 10; i++) begin
      dot_step((i < 8) ? 3'(i) : 3'd1);
      n_checks++;
      if (pix_code !== 4'(ec1[i]) || is_background !== (ec1[i] == 0)) begin
        n_fail++;
        $display("FAIL mc_gate_1bpp dot %0d: got code %0h bg %0b want code %0h bg %0b",
                 i, pix_code, is_background, ec1[i], ec1[i] == 0);
      end
    end
    n_checks++;
    if (pix_attr !== 12'h7AB) begin
      n_fail++;
      $display("FAIL mc_gate_attr: got %0h want 7ab", pix_attr);
    end
    // Attribute MSB set: 2bpp applies.
    prep_cell(8'h80, 12'h8AB, 3'd0, 2'b01, 1'b1);
    for (int i = 0; i < 10; i++) begin
      dot_step((i < 8) ? 3'(i) : 3'd1);
      n_checks++;
      if (pix_code !== 4'(ec2[i]) || is_background !== (ec2[i] == 0)) begin
        n_fail++;
        $display("FAIL mc_gate_2bpp dot %0d: got code %0h bg %0b want code %0h bg %0b",
                 i, pix_code, is_background, ec2[i], ec2[i] == 0);
      end
    end
  endtask

  task automatic test_4bpp();
`ifdef PIXEL_SHIFTER_4BPP_EN
    int ec[10] = '{3, 3, 3, 3, 12, 12, 12, 12, 0, 0};
    int eb[10] = '{1, 1, 1, 1, 0, 0, 0, 0, 1, 1};
`else
    int ec[10] = '{0, 0, 1, 1, 1, 1, 0, 0, 0, 0};
    int eb[10] = '{1, 1, 0, 0, 0, 0, 1, 1, 1, 1};
`endif
    int e11[10] = '{0, 0, 1, 1, 1, 1, 0, 0, 0, 0};
    prep_cell(8'h3C, 12'h000, 3'd5, 2'b10, 1'b0);
    for (int i = 0; i < 10; i++) begin
      dot_step((i < 8) ? 3'(5 + i) : 3'd6);
      n_checks++;
      if (pix_code !== 4'(ec[i]) || is_background !== 1'(eb[i])) begin
        n_fail++;
        $display("FAIL mode10 dot %0d: got code %0h bg %0b want code %0h bg %0d",
                 i, pix_code, is_background, ec[i], eb[i]);
      end
    end
    // Reserved mode falls back to 1bpp.
    prep_cell(8'h3C, 12'h000, 3'd5, 2'b11, 1'b0);
    for (int i = 0; i < 10; i++) begin
      dot_step((i < 8) ? 3'(5 + i) : 3'd6);
      n_checks++;
      if (pix_code !== 4'(e11[i]) || is_background !== (e11[i] == 0)) begin
        n_fail++;
        $display("FAIL mode11 dot %0d: got code %0h bg %0b want code %0h",
                 i, pix_code, is_background, e11[i]);
      end
    end
  endtask

  task automatic test_xscroll();
    logic [2:0] xp;
    prep_cell(8'h80, 12'h000, 3'd3, 2'b00, 1'b0);
    xscroll = 3'd5;  // not captured: must not move the load point
    for (int i = 0; i < 16; i++) begin
      xp = 3'(7 + i);
      dot_step(xp);
      n_checks++;
      if (pix_code !== ((xp == 3'd3) ? 4'h1 : 4'h0)) begin
        n_fail++;
        $display("FAIL xscroll xpos %0d: got code %0h want %0h",
                 xp, pix_code, (xp == 3'd3) ? 1 : 0);
      end
    end
  endtask

  task automatic test_reset_mid();
    prep_cell(8'hFF, 12'hFFF, 3'd0, 2'b00, 1'b0);
    dot_step(3'd0);
    dot_step(3'd1);
    n_checks++;
    if (pix_code !== 4'h1) begin
      n_fail++;
      $display("FAIL rst_mid_pre: got code %0h want 1", pix_code);
    end
    rst          = 1'b1;
    capture      = 1'b1;
    dot_rising_0 = 1'b1;
    xpos_mod     = 3'd0;
    cyc();
    rst          = 1'b0;
    capture      = 1'b0;
    dot_rising_0 = 1'b0;
    n_checks++;
    if (pix_code !== 4'h0 || is_background !== 1'b1 || pix_attr !== 12'h000) begin
      n_fail++;
      $display("FAIL rst_mid: got code %0h bg %0b attr %0h want 0 1 0",
               pix_code, is_background, pix_attr);
    end
    for (int i = 0; i < 16; i++) begin
      dot_step(3'(i));
      n_checks++;
      if (pix_code !== 4'h0 || is_background !== 1'b1) begin
        n_fail++;
        $display("FAIL rst_mid_after dot %0d: got code %0h bg %0b want 0 1",
                 i, pix_code, is_background);
      end
    end
  endtask

  task automatic test_random();
    logic [2:0] xp;
    int         phase;
    xp    = '0;
    phase = 0;
    for (int i = 0; i < 4000; i++) begin
      rst          = ($urandom_range(0, 399) == 0);
      capture      = ($urandom_range(0, 9) == 0);
      dot_rising_0 = (phase == 3);
      if (phase == 3) begin
        xp = ($urandom_range(0, 15) == 0) ? 3'($urandom) : 3'(xp + 1);
      end
      xpos_mod    = xp;
      phase       = (phase + 1) % 4;
      pixels_read = 8'($urandom);
      char_read   = 12'($urandom);
      xscroll     = 3'($urandom);
      if ($urandom_range(0, 31) == 0) bpp_mode = 2'($urandom);
      if ($urandom_range(0, 31) == 0) mc_gate = 1'($urandom);
      cyc();
      n_checks++;
      if (pix_code !== exp_code || is_background !== exp_bg || pix_attr !== exp_attr) begin
        n_fail++;
        $display("FAIL random cycle %0d: got code %0h bg %0b attr %0h want %0h %0b %0h",
                 i, pix_code, is_background, pix_attr, exp_code, exp_bg, exp_attr);
      end
    end
    rst          = 1'b0;
    capture      = 1'b0;
    dot_rising_0 = 1'b0;
  endtask

  initial begin
    rst          = 1'b1;
    dot_rising_0 = 1'b0;
    capture      = 1'b0;
    pixels_read  = '0;
    char_read    = '0;
    xscroll      = '0;
    xpos_mod     = '0;
    bpp_mode     = 2'b00;
    mc_gate      = 1'b0;
    test_reset();
    test_1bpp();
    test_2bpp();
    test_mc_gate();
    test_4bpp();
    test_xscroll();
    test_reset_mid();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
